// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// bulk-clear FSM encoding and the address-width helper.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_rd_port.sv
// One combinational read port: decode, x0 masking and, when REGFILE_BYPASS_EN
// is defined, same-cycle forwarding of the writeback value.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW  = addr_width(NREG)
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREG],
  input  logic [NREG-1:0] pend,
`ifdef REGFILE_BYPASS_EN
  input  logic            byp_en,
  input  logic            we,
  input  logic [AW-1:0]   wr,
  input  logic [XLEN-1:0] wd,
  input  logic            pend_set,
  input  logic [AW-1:0]   pend_addr,
`endif
  output logic [XLEN-1:0] data,
  output logic            data_pend
);

  always_comb begin
    data      = '0;
    data_pend = 1'b0;
    if (addr != '0) begin
      data      = regs[addr];
      data_pend = pend[addr];
    end
`ifdef REGFILE_BYPASS_EN
    // A retiring write forwards its data; a new op issued to the same
    // register in the same cycle keeps the register marked pending.
    if (byp_en && we && (wr != '0) && (wr == addr)) begin
      data      = wd;
      data_pend = pend_set && (pend_addr == addr);
    end
`endif
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD read ports, one write port, x0 hardwired to zero,
// a per-register pending scoreboard and a sequential bulk-clear engine.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = addr_width(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      wr,
  input  logic [XLEN-1:0]    wd,
  input  logic [NRD*AW-1:0]  rr,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]     rd_pend,
  input  logic               pend_set,
  input  logic [AW-1:0]      pend_addr,
  input  logic               clr_req,
  output logic               clr_busy
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] pend_reg;
  state_e          state_reg;
  logic [AW-1:0]   cnt_reg;
  logic            clr_busy_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
      pend_reg     <= '0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      clr_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (we && (wr != '0)) begin
            regs_reg[wr] <= wd;
            pend_reg[wr] <= 1'b0;
          end
          // Issued after the retire so a same-address set wins.
          if (pend_set && (pend_addr != '0)) begin
            pend_reg[pend_addr] <= 1'b1;
          end
          if (clr_req) begin
            state_reg    <= CLEAR;
            cnt_reg      <= AW'(1);
            clr_busy_reg <= 1'b1;
          end
        end
        CLEAR: begin
          regs_reg[cnt_reg] <= '0;
          pend_reg[cnt_reg] <= 1'b0;
          if (cnt_reg == AW'(NREG - 1)) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            clr_busy_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + AW'(1);
          end
        end
        default: begin
          state_reg    <= IDLE;
          clr_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_reg;

`ifdef REGFILE_BYPASS_EN
  logic idle;
  assign idle = (state_reg == IDLE);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      regfile_rd_port #(
        .XLEN (XLEN),
        .NREG (NREG)
      ) u_port (
        .addr      (rr[gi*AW +: AW]),
        .regs      (regs_reg),
        .pend      (pend_reg),
`ifdef REGFILE_BYPASS_EN
        .byp_en    (idle),
        .we        (we),
        .wr        (wr),
        .wd        (wd),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
`endif
        .data      (rd[gi*XLEN +: XLEN]),
        .data_pend (rd_pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb (default 32x32, two read ports).
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                we;
  logic [AW-1:0]       wr;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   rr;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_pend;
  logic                pend_set;
  logic [AW-1:0]       pend_addr;
  logic                clr_req;
  logic                clr_busy;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr        (wr),
    .wd        (wd),
    .rr        (rr),
    .rd        (rd),
    .rd_pend   (rd_pend),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 = rd data, 1 = rd_pend, 2 = clr_busy
    int          port;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] fill_val(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  task automatic push(input string tag, input int kind, input int port, input logic [31:0] exp);
    chk_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic exp_rd(input string tag, input int port, input logic [31:0] d);
    push(tag, 0, port, d);
  endtask

  task automatic exp_pend(input string tag, input int port, input logic p);
    push(tag, 1, port, {31'd0, p});
  endtask

  task automatic exp_busy(input string tag, input logic b);
    push(tag, 2, 0, {31'd0, b});
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic check_now();
    chk_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = rd[e.port*XLEN +: XLEN];
        1:       obs = {31'd0, rd_pend[e.port]};
        default: obs = {31'd0, clr_busy};
      endcase
      n_cmp++;
      assert (obs === e.exp) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_rr(input int a0, input int a1);
    rr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; we = 1'b0; wr = '0; wd = '0; pend_set = 1'b0;
    pend_addr = '0; clr_req = 1'b0;
    set_rr(5, 5);
    exp_rd("reset_rd0", 0, 32'h0);
    exp_pend("reset_pend0", 0, 1'b0);
    exp_busy("reset_busy", 1'b0);
    check_now();

    @(negedge clk);
    rst = 1'b1;
    cyc();
    exp_rd("x5_init", 0, 32'h0);
    exp_pend("x5_init_pend", 0, 1'b0);
    check_now();

    // Write x5; stored value visible next cycle (same cycle only with bypass)
    we = 1'b1; wr = 5; wd = 32'hDEADBEEF;
    exp_rd("x5_same_cycle", 0, BYP ? 32'hDEADBEEF : 32'h0);
    check_now();
    cyc();
    we = 1'b0;
    exp_rd("x5_written", 0, 32'hDEADBEEF);
    check_now();

    // x0 protection
    we = 1'b1; wr = 0; wd = 32'hFFFF_FFFF; set_rr(0, 0);
    exp_rd("x0_same_cycle", 0, 32'h0);
    check_now();
    cyc();
    we = 1'b0;
    exp_rd("x0_rd0", 0, 32'h0);
    exp_rd("x0_rd1", 1, 32'h0);
    check_now();
    pend_set = 1'b1; pend_addr = 0;
    cyc();
    pend_set = 1'b0;
    exp_pend("x0_pend0", 0, 1'b0);
    exp_pend("x0_pend1", 1, 1'b0);
    check_now();

    // Scoreboard on x7
    set_rr(7, 7);
    pend_set = 1'b1; pend_addr = 7;
    exp_pend("x7_pend_before_edge", 0, 1'b0);
    check_now();
    cyc();
    pend_set = 1'b0;
    exp_pend("x7_pend_set0", 0, 1'b1);
    exp_pend("x7_pend_set1", 1, 1'b1);
    check_now();
    we = 1'b1; wr = 7; wd = 32'h0000_1234;
    exp_pend("x7_retire_same_cycle", 0, BYP ? 1'b0 : 1'b1);
    check_now();
    cyc();
    we = 1'b0;
    exp_rd("x7_data", 0, 32'h0000_1234);
    exp_pend("x7_pend_cleared", 0, 1'b0);
    check_now();
    we = 1'b1; wr = 7; wd = 32'h0000_ABCD; pend_set = 1'b1; pend_addr = 7;
    exp_rd("x7_wrset_same_rd", 0, BYP ? 32'h0000_ABCD : 32'h0000_1234);
    exp_pend("x7_wrset_same_pend", 0, 1'b0 | BYP);
    check_now();
    cyc();
    we = 1'b0; pend_set = 1'b0;
    exp_rd("x7_wrset_data", 0, 32'h0000_ABCD);
    exp_pend("x7_wrset_pend", 0, 1'b1);
    check_now();

    // Fill x1..x31 for the bulk clear
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; wr = AW'(i); wd = fill_val(i);
      cyc();
    end
    we = 1'b0;
    set_rr(3, 31);
    exp_rd("fill_x3", 0, fill_val(3));
    exp_rd("fill_x31", 1, fill_val(31));
    check_now();
    pend_set = 1'b1; pend_addr = 12;
    cyc();
    pend_set = 1'b0;
    set_rr(12, 0);
    exp_pend("x12_pend", 0, 1'b1);
    check_now();

    // Bulk clear: busy for exactly NREG-1 cycles
    clr_req = 1'b1;
    exp_busy("clr_req_busy_before_edge", 1'b0);
    check_now();
    cyc();
    clr_req = 1'b0;
    for (int k = 0; k < NREG - 1; k++) begin
      exp_busy($sformatf("clear_busy_k%0d", k), 1'b1);
      if (k == 5) begin
        we = 1'b1; wr = 3; wd = 32'h0000_0033; pend_set = 1'b1; pend_addr = 3;
        set_rr(3, 31);
        exp_rd("mid_clear_x3", 0, 32'h0);
        exp_pend("mid_clear_x3_pend", 0, 1'b0);
        exp_rd("mid_clear_x31_live", 1, fill_val(31));
      end
      if (k == 20) clr_req = 1'b1;
      check_now();
      cyc();
      we = 1'b0; pend_set = 1'b0; clr_req = 1'b0;
    end
    exp_busy("clear_done_busy", 1'b0);
    check_now();
    for (int i = 0; i < NREG; i++) begin
      set_rr(i, NREG - 1 - i);
      exp_rd($sformatf("post_clear_rd_x%0d", i), 0, 32'h0);
      exp_pend($sformatf("post_clear_pend_x%0d", i), 0, 1'b0);
      exp_pend($sformatf("post_clear_pend1_x%0d", NREG - 1 - i), 1, 1'b0);
      check_now();
      cyc();
    end

    // Reset in the middle of a clear
    we = 1'b1; wr = 4; wd = 32'h0000_0044;
    cyc();
    wr = 20; wd = 32'h0000_2020;
    cyc();
    we = 1'b0;
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int k = 1; k < 10; k++) cyc();
    set_rr(4, 20);
    exp_busy("clear_cycle10_busy", 1'b1);
    exp_rd("clear_cycle10_x20", 1, 32'h0000_2020);
    check_now();
    rst = 1'b0;
    exp_busy("rst_mid_clear_busy", 1'b0);
    exp_rd("rst_mid_clear_x4", 0, 32'h0);
    exp_rd("rst_mid_clear_x20", 1, 32'h0);
    check_now();
    cyc();
    rst = 1'b1;
    cyc();
    exp_busy("after_rst_idle", 1'b0);
    check_now();
    we = 1'b1; wr = 6; wd = 32'h0000_0066; set_rr(6, 20);
    cyc();
    we = 1'b0;
    exp_rd("after_rst_write_x6", 0, 32'h0000_0066);
    exp_rd("after_rst_x20", 1, 32'h0);
    exp_busy("after_rst_still_idle", 1'b0);
    check_now();

    // Forwarding check on x9 (old value 0)
    we = 1'b1; wr = 9; wd = 32'hA5A5_A5A5; set_rr(0, 9);
    exp_rd("x9_same_cycle_rd1", 1, BYP ? 32'hA5A5_A5A5 : 32'h0);
    exp_pend("x9_same_cycle_pend1", 1, 1'b0);
    exp_rd("x9_rd0_zero", 0, 32'h0);
    check_now();
    cyc();
    we = 1'b0;
    exp_rd("x9_next_cycle_rd1", 1, 32'hA5A5_A5A5);
    check_now();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
